// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 16-bit stack CPU: owns the fetch PC, keeps at most one
// instruction-memory read in flight and buffers returned words in a prefetch FIFO.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_INC   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_ack,
    input  logic [15:0]             imem_data,
    output logic [15:0]             ir,
    output logic [ADDR_W-1:0]       ir_pc,
    output logic                    ir_valid,
    input  logic                    ir_take,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam int unsigned        CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(PC_INC);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [15:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    // Fetch FSM state and its registered memory-side outputs
    state_e              state_q;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   fetch_pc_q;

    // Prefetch FIFO
    entry_t              fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                push_en;
    logic                pop_en;
    logic                issue_ok;
    logic [CNT_W-1:0]    count_after_pop;
    entry_t              push_entry;

    // A redirect overrides both the push of acked data and a consumer pop.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        push_en         = 1'b0;
        pop_en          = 1'b0;
        issue_ok        = 1'b0;
        count_after_pop = count_q;
        push_entry      = '{instr: imem_data, pc: addr_q};
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;

        push_en         = (state_q == ST_WAIT) && imem_ack && !redirect;
        pop_en          = ir_take && (count_q != '0) && !redirect;
        count_after_pop = count_q - CNT_W'(pop_en);
        issue_ok        = (count_after_pop < FULL_CNT) && !redirect;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
            count_d  = count_after_pop + CNT_W'(push_en);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc_q <= redirect_pc;
            end
            case (state_q)
                ST_IDLE: begin
                    if (issue_ok) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        if (!redirect) begin
                            fetch_pc_q <= fetch_pc_q + PC_STEP;
                        end
                    end else if (redirect) begin
                        // Read stays on the bus; its data will be thrown away
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage is reset because ir/ir_pc read it directly and must
    // never show X, even while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push_en) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ir         = fifo_mem_q[rd_ptr_q].instr;
    assign ir_pc      = fifo_mem_q[rd_ptr_q].pc;
    assign ir_valid   = (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural instruction memory with
// programmable latency and a scoreboard of expected FIFO contents.
module tb_instr_fetch_unit;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_take;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [2:0]  fifo_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    int          req_age;
    logic        prev_req;
    logic        drop_pending;
    logic        spurious;
    logic [15:0] exp_pc;
    logic [15:0] held_addr;
    exp_t        exp_q[$];
    logic [15:0] issued_q[$];

    instr_fetch_unit #(
        .ADDR_W   (16),
        .DEPTH    (4),
        .PC_INC   (1),
        .RESET_PC (16'h0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_take     (ir_take),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge. Memory responds,
    // the scoreboard is updated for the coming edge, and FIFO occupancy is
    // compared after it.
    task automatic tick();
        exp_t e;
        logic req_now;
        logic ack_now;
        req_now   = imem_req;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        if (!reset) begin
            if (req_now && req_age >= lat) begin
                imem_ack  = 1'b1;
                imem_data = imem_addr ^ 16'hA500;
            end else if (!req_now && spurious) begin
                imem_ack  = 1'b1;
                imem_data = 16'hDEAD;
            end
            if (req_now && !prev_req) begin
                check("issue_addr", imem_addr, exp_pc);
                issued_q.push_back(imem_addr);
                held_addr = imem_addr;
            end else if (req_now) begin
                check("addr_stable", imem_addr, held_addr);
            end
            if (exp_q.size() > 0) begin
                check("head_pc", ir_pc, exp_q[0].pc);
                check("head_ir", ir, exp_q[0].data);
                if (ir_take && !redirect) void'(exp_q.pop_front());
            end
            if (req_now && imem_ack) begin
                if (!redirect && !drop_pending) begin
                    e.pc   = exp_pc;
                    e.data = exp_pc ^ 16'hA500;
                    exp_q.push_back(e);
                    exp_pc = exp_pc + 16'd1;
                end
                drop_pending = 1'b0;
            end
            if (redirect) begin
                exp_q.delete();
                exp_pc = redirect_pc;
                if (req_now && !imem_ack) drop_pending = 1'b1;
            end
        end else begin
            exp_q.delete();
            exp_pc       = 16'h0000;
            drop_pending = 1'b0;
        end
        ack_now = imem_ack;
        @(posedge clock);
        if (reset || (req_now && ack_now)) req_age = 0;
        else if (req_now) req_age++;
        prev_req = reset ? 1'b0 : req_now;
        @(negedge clock);
        redirect = 1'b0;
        check("fifo_count", fifo_count, exp_q.size());
        check("ir_valid", ir_valid, exp_q.size() != 0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ir_take = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        issued_q.delete();
    endtask

    task automatic wait_req_rise(input string tag, input int budget);
        int n = 0;
        while (!(imem_req && !prev_req) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(imem_req && !prev_req), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!ir_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(ir_valid), 32'd1);
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        ir_take      = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 16'h0000;
        imem_ack     = 1'b0;
        imem_data    = 16'h0000;
        lat          = 0;
        req_age      = 0;
        prev_req     = 1'b0;
        drop_pending = 1'b0;
        spurious     = 1'b0;
        exp_pc       = 16'h0000;
        held_addr    = 16'h0000;
        @(negedge clock);

        // Reset state
        do_reset();
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_count", fifo_count, 3'd0);
        check("rst_valid", ir_valid, 1'b0);
        check("rst_ir", ir, 16'h0000);
        check("rst_ir_pc", ir_pc, 16'h0000);

        // Fill with zero-latency memory and no consumer
        for (int i = 0; i < 12; i++) tick();
        check("fill_issued", issued_q.size(), 4);
        for (int i = 0; i < 4 && i < issued_q.size(); i++) check("fill_addr", issued_q[i], i);
        check("fill_req_off", imem_req, 1'b0);
        check("fill_count", fifo_count, 3'd4);
        check("fill_ir", ir, 16'hA500);
        check("fill_ir_pc", ir_pc, 16'h0000);

        // One pop from a full FIFO frees a slot for address 4
        ir_take = 1'b1;
        tick();
        ir_take = 1'b0;
        check("pop_count", fifo_count, 3'd3);
        check("refill_req", imem_req, 1'b1);
        check("refill_addr", imem_addr, 16'h0004);
        tick();
        check("refill_count", fifo_count, 3'd4);
        check("refill_head_pc", ir_pc, 16'h0001);
        check("refill_head_ir", ir, 16'hA501);

        // Three-cycle memory with a continuous consumer
        lat = 2;
        issued_q.delete();
        ir_take = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        ir_take = 1'b0;
        check("lat_issued_min", 32'(issued_q.size() >= 5), 32'd1);
        if (issued_q.size() > 0) check("lat_first_addr", issued_q[0], 16'h0005);
        for (int i = 1; i < issued_q.size(); i++) check("lat_consecutive", issued_q[i], issued_q[0] + 16'(i));

        // Redirect while the read of address 2 waits on a slow memory
        do_reset();
        lat = 2;
        n = 0;
        while (!(imem_req && !prev_req && imem_addr == 16'h0002) && n < 40) begin
            tick();
            n++;
        end
        check("drain_setup_addr", imem_addr, 16'h0002);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        check("drain_req_held", imem_req, 1'b1);
        check("drain_addr_held", imem_addr, 16'h0002);
        check("drain_valid", ir_valid, 1'b0);
        wait_req_rise("drain_new_req", 20);
        check("drain_new_addr", imem_addr, 16'h0040);
        wait_valid("drain_valid_wait", 20);
        check("drain_head_pc", ir_pc, 16'h0040);
        check("drain_head_ir", ir, 16'hA540);

        // Redirect in the same cycle as the ack
        do_reset();
        lat = 0;
        n = 0;
        while (!(exp_q.size() >= 2 && imem_req && !prev_req) && n < 30) begin
            tick();
            n++;
        end
        check("redir_ack_setup", 32'(imem_req && !prev_req), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h0123;
        tick();
        check("redir_ack_count", fifo_count, 3'd0);
        check("redir_ack_req", imem_req, 1'b0);
        wait_req_rise("redir_ack_new_req", 10);
        check("redir_ack_addr", imem_addr, 16'h0123);

        // Redirect together with a pop
        n = 0;
        while (exp_q.size() < 2 && n < 30) begin
            tick();
            n++;
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        ir_take     = 1'b1;
        tick();
        ir_take = 1'b0;
        check("redir_take_count", fifo_count, 3'd0);
        check("redir_take_valid", ir_valid, 1'b0);
        wait_valid("redir_take_wait", 20);
        check("redir_take_head", ir_pc, 16'h0200);

        // Ack without a request must be ignored
        n = 0;
        while (imem_req && n < 10) begin
            tick();
            n++;
        end
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        check("spurious_count", fifo_count, exp_q.size());

        // PC wrap at 16'hFFFF, then reset in the middle of a read
        do_reset();
        lat         = 0;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        wait_req_rise("wrap_req", 10);
        check("wrap_top_addr", imem_addr, 16'hFFFF);
        tick();
        wait_req_rise("wrap_next_req", 10);
        check("wrap_zero_addr", imem_addr, 16'h0000);
        lat   = 2;
        reset = 1'b1;
        tick();
        check("midrst_req", imem_req, 1'b0);
        check("midrst_count", fifo_count, 3'd0);
        check("midrst_valid", ir_valid, 1'b0);
        reset = 1'b0;
        issued_q.delete();
        wait_req_rise("midrst_new_req", 10);
        check("midrst_addr", imem_addr, 16'h0000);
        wait_valid("midrst_valid_wait", 20);
        check("midrst_head_pc", ir_pc, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the 16-bit stack CPU. Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions, each tagged with its PC, in a small prefetch FIFO. The FIFO head drives the controller's IR.
- Branch, call and return redirects flush the buffer. Any in-flight read is allowed to complete and its data is discarded.

Parameters:
- ADDR_W, 16, width of PC and instruction-memory address
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
- PC_INC, 1, address increment per sequential instruction
- RESET_PC, 16'h0000, fetch PC loaded on reset

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  read address, valid while imem_req=1
- imem_ack  input  1  memory completes the read this cycle; imem_data valid
- imem_data  input  16  instruction word returned with imem_ack
- ir  output  16  instruction at FIFO head
- ir_pc  output  ADDR_W  address of the instruction at FIFO head
- ir_valid  output  1  FIFO non-empty; ir and ir_pc are meaningful
- ir_take  input  1  consumer pops the head this cycle (ignored if ir_valid=0)
- redirect  input  1  discard buffered or in-flight fetches; restart at redirect_pc
- redirect_pc  input  ADDR_W  new fetch address, sampled when redirect=1
- fifo_count  output  clog2(DEPTH)+1  number of valid FIFO entries

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc=RESET_PC, FIFO empty, fifo_count=0, ir_valid=0.
  - imem_req=0, imem_addr=RESET_PC, state=IDLE.
  - ir and ir_pc hold don't-care values but are driven, not X-propagating; implement them as 0 after reset.
  - Reset mid-transaction abandons the outstanding read. Memory is also reset by the same signal.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; data will be kept.
  - DRAIN: request outstanding; data will be discarded.
- Issue rule:
  - In IDLE, a request is issued when fifo_count (after this cycle's pop) < DEPTH and redirect=0.
  - On issue: imem_req=1, imem_addr=fetch_pc, state goes to WAIT.
  - At most one read is outstanding.
- Handshake:
  - While a read is outstanding, imem_req stays 1 and imem_addr stays stable until the cycle imem_ack=1.
  - imem_ack may be high in the same cycle req first rises.
  - imem_ack while imem_req=0 is ignored.
- WAIT + ack, no redirect:
  - Push {imem_data, imem_addr} into the FIFO.
  - fetch_pc += PC_INC, wrapping modulo 2^ADDR_W.
  - Go to IDLE. The next request may issue in the following cycle.
  - Sustained throughput with ack in the same cycle is 1 instruction per 2 cycles.
- Pop:
  - ir_take=1 with ir_valid=1 advances the head at the clock edge.
  - Push and pop in the same cycle are both honoured; fifo_count is unchanged.
  - The FIFO never overflows, because issue is gated by space.
  - Pop while empty is a no-op.
- Redirect (highest priority):
  - At the edge, the FIFO is flushed (fifo_count=0) and fetch_pc=redirect_pc.
  - A same-cycle ir_take is ignored.
  - If no read is outstanding, or ack arrives in the redirect cycle: go to IDLE, and any acked data is discarded. The first request to redirect_pc appears in the next cycle.
  - If a read is outstanding and ack=0: go to DRAIN, holding req and addr stable.
  - DRAIN + ack: discard the data and go to IDLE.
- Redirect while in DRAIN: fetch_pc is updated to the newest redirect_pc and the state stays DRAIN.
- ir_valid is 0 in the cycle after any redirect.
- Outputs ir, ir_pc and ir_valid come from registered FIFO state. There is no combinational path from imem_data or redirect to ir.

Test Plan:
- Reset then ack every request in the same cycle, memory word = addr ^ 16'hA500; hold ir_take=0:
  - imem_addr sequence is 0,1,2,3 and imem_req stays 0 once fifo_count=4.
  - ir=16'hA500, ir_pc=0.
- Full FIFO, then pulse ir_take for one cycle:
  - fifo_count 4->3, then a request is issued to addr 4.
  - After ack, fifo_count=4 and the head becomes ir_pc=1.
- Memory latency 3 cycles (ack 2 cycles after req rises): imem_addr stays constant across all 3 cycles of each request, and ir_pc values are consecutive.
- Redirect to 16'h0040 while a request to addr 2 is in WAIT and ack is delayed 2 cycles:
  - State goes to DRAIN and the addr-2 data is discarded.
  - Next request is 16'h0040; ir_valid=0 until it returns with ir_pc=16'h0040.
- Redirect and imem_ack in the same cycle, and separately redirect with ir_take:
  - No push occurs and fifo_count=0 next cycle.
  - Next imem_addr=redirect_pc.
- fetch_pc=16'hFFFF wrap:
  - After the ack at 16'hFFFF, the next imem_addr is 16'h0000.
  - Assert reset mid-WAIT: next cycle imem_req=0, fifo_count=0, and after release fetch restarts at 0.
